// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, load funct3 codes
// and the fallback write value used for out-of-range source selects.
package wb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StWaitMem
    } wb_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [31:0] WB_DEFAULT_VAL = 32'hDEADBEEF;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: shifts the addressed lane down and sign/zero-extends it
// according to the load funct3.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic [2:0]       mem_size_i,
    input  logic [OFF_W-1:0] mem_off_i,
    output logic [XLEN-1:0]  ext_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = mem_data_i >> {mem_off_i, 3'b000};

    always_comb begin
        ext_o = mem_data_i;
        case (mem_size_i)
            LB:  ext_o = XLEN'($signed(shifted[7:0]));
            LH:  ext_o = XLEN'($signed(shifted[15:0]));
            LW:  ext_o = XLEN'($signed(shifted[31:0]));
            LBU: ext_o = XLEN'(shifted[7:0]);
            LHU: ext_o = XLEN'(shifted[15:0]);
            // Doubleword forms only exist on RV64; RV32 treats them as unknown codes.
            LWU: if (XLEN == 64) ext_o = XLEN'(shifted[31:0]);
            LD:  if (XLEN == 64) ext_o = shifted;
            default: ext_o = mem_data_i;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Registered writeback stage: source select or load-wait, driving one register-file
// write port with a single-cycle write-enable pulse.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NSRC        = 4,
    parameter int unsigned MEM_SRC     = 2,
    parameter int unsigned REG_AW      = 5,
    parameter logic [31:0] DEFAULT_VAL = WB_DEFAULT_VAL,
    localparam int unsigned SEL_W      = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int unsigned OFF_W      = $clog2(XLEN / 8)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [SEL_W-1:0]     rf_sel_i,
    input  logic [REG_AW-1:0]    rd_addr_i,
    input  logic                 rf_en_i,
    input  logic [NSRC*XLEN-1:0] src_i,
    input  logic [2:0]           mem_size_i,
    input  logic [OFF_W-1:0]     mem_off_i,
    input  logic                 mem_valid_i,
    input  logic [XLEN-1:0]      mem_data_i,
    output logic                 we_o,
    output logic [REG_AW-1:0]    wa_o,
    output logic [XLEN-1:0]      wd_o
);

    localparam logic [SEL_W-1:0] MemSel = SEL_W'(MEM_SRC);

    wb_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] wa_q, wa_d;
    logic [XLEN-1:0]   wd_q, wd_d;
    logic [REG_AW-1:0] lat_rd_q, lat_rd_d;
    logic              lat_en_q, lat_en_d;
    logic [2:0]        lat_size_q, lat_size_d;
    logic [OFF_W-1:0]  lat_off_q, lat_off_d;

    logic [XLEN-1:0]   sel_data;
    logic [XLEN-1:0]   load_data;

    // Selects beyond NSRC fall back to DEFAULT_VAL.
    always_comb begin
        sel_data = XLEN'(DEFAULT_VAL);
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (rf_sel_i == SEL_W'(i)) begin
                sel_data = src_i[i*XLEN +: XLEN];
            end
        end
    end

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .mem_data_i (mem_data_i),
        .mem_size_i (lat_size_q),
        .mem_off_i  (lat_off_q),
        .ext_o      (load_data)
    );

    assign in_ready_o = (state_q == StIdle);

    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        lat_rd_d   = lat_rd_q;
        lat_en_d   = lat_en_q;
        lat_size_d = lat_size_q;
        lat_off_d  = lat_off_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    if (rf_sel_i == MemSel) begin
                        lat_rd_d   = rd_addr_i;
                        lat_en_d   = rf_en_i;
                        lat_size_d = mem_size_i;
                        lat_off_d  = mem_off_i;
                        state_d    = StWaitMem;
                    end else begin
                        we_d = rf_en_i && (rd_addr_i != '0);
                        wa_d = rd_addr_i;
                        wd_d = sel_data;
                    end
                end
            end
            StWaitMem: begin
                if (mem_valid_i) begin
                    we_d    = lat_en_q && (lat_rd_q != '0);
                    wa_d    = lat_rd_q;
                    wd_d    = load_data;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            lat_rd_q   <= '0;
            lat_en_q   <= 1'b0;
            lat_size_q <= '0;
            lat_off_q  <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            lat_rd_q   <= lat_rd_d;
            lat_en_q   <= lat_en_d;
            lat_size_q <= lat_size_d;
            lat_off_q  <= lat_off_d;
        end
    end

    assign we_o = we_q;
    assign wa_o = wa_q;
    assign wd_o = wd_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (XLEN=32, NSRC=5 so that out-of-range selects are
// reachable, MEM_SRC=2).
module tb_writeback_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NSRC   = 5;
    localparam int unsigned REG_AW = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           rf_sel;
    logic [REG_AW-1:0]    rd_addr;
    logic                 rf_en;
    logic [NSRC*XLEN-1:0] src;
    logic [2:0]           mem_size;
    logic [1:0]           mem_off;
    logic                 mem_valid;
    logic [XLEN-1:0]      mem_data;
    logic                 we;
    logic [REG_AW-1:0]    wa;
    logic [XLEN-1:0]      wd;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_unit #(
        .XLEN        (XLEN),
        .NSRC        (NSRC),
        .MEM_SRC     (2),
        .REG_AW      (REG_AW),
        .DEFAULT_VAL (32'hDEADBEEF)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .rf_sel_i    (rf_sel),
        .rd_addr_i   (rd_addr),
        .rf_en_i     (rf_en),
        .src_i       (src),
        .mem_size_i  (mem_size),
        .mem_off_i   (mem_off),
        .mem_valid_i (mem_valid),
        .mem_data_i  (mem_data),
        .we_o        (we),
        .wa_o        (wa),
        .wd_o        (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a load, wait one cycle, then present the memory word for one cycle.
    // Returns just after the edge on which the write is registered.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] size,
                           input logic [1:0] off, input logic [31:0] data);
        in_valid = 1'b1;
        rf_sel   = 3'd2;
        rd_addr  = rd;
        rf_en    = 1'b1;
        mem_size = size;
        mem_off  = off;
        tick();
        in_valid = 1'b0;
        tick();
        mem_valid = 1'b1;
        mem_data  = data;
        tick();
        mem_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rf_sel    = '0;
        rd_addr   = '0;
        rf_en     = 1'b0;
        src       = '0;
        mem_size  = '0;
        mem_off   = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        src[0*32 +: 32] = 32'hA0A0_A0A0;
        src[1*32 +: 32] = 32'hB1B1_B1B1;
        src[2*32 +: 32] = 32'h2222_2222;
        src[3*32 +: 32] = 32'h1234_5678;
        src[4*32 +: 32] = 32'hC4C4_C4C4;

        tick();
        tick();
        check("reset_we", {31'd0, we}, 32'd0);
        check("reset_wa", {27'd0, wa}, 32'd0);
        check("reset_wd", wd, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", {31'd0, in_ready}, 32'd1);

        // Single non-load write.
        in_valid = 1'b1; rf_sel = 3'd3; rd_addr = 5'd5; rf_en = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_we", {31'd0, we}, 32'd1);
        check("single_wa", {27'd0, wa}, 32'd5);
        check("single_wd", wd, 32'h1234_5678);
        tick();
        check("single_we_drop", {31'd0, we}, 32'd0);
        check("single_wd_hold", wd, 32'h1234_5678);

        // Back-to-back non-load writes.
        in_valid = 1'b1; rf_sel = 3'd0; rd_addr = 5'd1;
        tick();
        check("b2b1_we", {31'd0, we}, 32'd1);
        check("b2b1_wa", {27'd0, wa}, 32'd1);
        check("b2b1_wd", wd, 32'hA0A0_A0A0);
        check("b2b1_ready", {31'd0, in_ready}, 32'd1);
        rf_sel = 3'd1; rd_addr = 5'd2;
        tick();
        check("b2b2_we", {31'd0, we}, 32'd1);
        check("b2b2_wa", {27'd0, wa}, 32'd2);
        check("b2b2_wd", wd, 32'hB1B1_B1B1);
        check("b2b2_ready", {31'd0, in_ready}, 32'd1);
        rf_sel = 3'd4; rd_addr = 5'd3;
        tick();
        check("b2b3_we", {31'd0, we}, 32'd1);
        check("b2b3_wa", {27'd0, wa}, 32'd3);
        check("b2b3_wd", wd, 32'hC4C4_C4C4);
        // rf_en low: no write, but address/data still update.
        rf_sel = 3'd0; rd_addr = 5'd7; rf_en = 1'b0;
        tick();
        in_valid = 1'b0;
        check("noen_we", {31'd0, we}, 32'd0);
        check("noen_wa", {27'd0, wa}, 32'd7);
        check("noen_wd", wd, 32'hA0A0_A0A0);

        // LB at offset 2; mem_valid during acceptance must be ignored.
        in_valid = 1'b1; rf_sel = 3'd2; rd_addr = 5'd9; rf_en = 1'b1;
        mem_size = 3'b000; mem_off = 2'd2; mem_valid = 1'b1; mem_data = 32'hFFFF_FFFF;
        tick();
        // Competing request while waiting; must be ignored.
        rf_sel = 3'd0; rd_addr = 5'd4; mem_valid = 1'b0;
        check("lb_accept_we", {31'd0, we}, 32'd0);
        check("lb_wait_ready0", {31'd0, in_ready}, 32'd0);
        tick();
        check("lb_wait_ready1", {31'd0, in_ready}, 32'd0);
        check("lb_wait_we1", {31'd0, we}, 32'd0);
        tick();
        check("lb_wait_ready2", {31'd0, in_ready}, 32'd0);
        mem_valid = 1'b1; mem_data = 32'h0080_0000;
        in_valid = 1'b0;
        tick();
        mem_valid = 1'b0;
        check("lb_we", {31'd0, we}, 32'd1);
        check("lb_wa", {27'd0, wa}, 32'd9);
        check("lb_wd", wd, 32'hFFFF_FF80);
        check("lb_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        check("lb_we_drop", {31'd0, we}, 32'd0);
        check("lb_wa_hold", {27'd0, wa}, 32'd9);

        // LHU to x0: write suppressed, data still updates.
        do_load(5'd0, 3'b101, 2'd2, 32'hBEEF_0000);
        check("lhu_x0_we", {31'd0, we}, 32'd0);
        check("lhu_x0_wa", {27'd0, wa}, 32'd0);
        check("lhu_x0_wd", wd, 32'h0000_BEEF);

        do_load(5'd10, 3'b001, 2'd0, 32'h0000_8001);
        check("lh_we", {31'd0, we}, 32'd1);
        check("lh_wd", wd, 32'hFFFF_8001);
        do_load(5'd11, 3'b100, 2'd3, 32'h80AB_CDEF);
        check("lbu_wd", wd, 32'h0000_0080);
        do_load(5'd12, 3'b010, 2'd0, 32'h8765_4321);
        check("lw_wd", wd, 32'h8765_4321);
        do_load(5'd13, 3'b111, 2'd1, 32'h1234_5678);
        check("raw_code_wd", wd, 32'h1234_5678);
        do_load(5'd14, 3'b110, 2'd1, 32'h89AB_CDEF);
        check("lwu_rv32_raw_wd", wd, 32'h89AB_CDEF);
        do_load(5'd15, 3'b000, 2'd1, 32'h0000_7F00);
        check("lb_pos_wd", wd, 32'h0000_007F);

        // Out-of-range selects fall back to the default value.
        tick();
        in_valid = 1'b1; rf_sel = 3'd5; rd_addr = 5'd6; rf_en = 1'b1;
        tick();
        check("def5_we", {31'd0, we}, 32'd1);
        check("def5_wa", {27'd0, wa}, 32'd6);
        check("def5_wd", wd, 32'hDEAD_BEEF);
        rf_sel = 3'd7; rd_addr = 5'd8;
        tick();
        in_valid = 1'b0;
        check("def7_wd", wd, 32'hDEAD_BEEF);

        // Reset while waiting for memory aborts the load.
        in_valid = 1'b1; rf_sel = 3'd2; rd_addr = 5'd20; mem_size = 3'b010; mem_off = 2'd0;
        tick();
        in_valid = 1'b0;
        check("abort_waiting", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_ready_async", {31'd0, in_ready}, 32'd1);
        check("abort_wd_async", wd, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_valid = 1'b1; mem_data = 32'h5555_AAAA;
        tick();
        mem_valid = 1'b0;
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        check("abort_wa", {27'd0, wa}, 32'd0);
        check("abort_wd", wd, 32'd0);
        tick();
        check("abort_we2", {31'd0, we}, 32'd0);

        // Normal operation resumes after the aborted load.
        in_valid = 1'b1; rf_sel = 3'd1; rd_addr = 5'd31;
        tick();
        in_valid = 1'b0;
        check("resume_we", {31'd0, we}, 32'd1);
        check("resume_wa", {27'd0, wa}, 32'd31);
        check("resume_wd", wd, 32'hB1B1_B1B1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
